// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the three-way memory port arbiter: response tags,
// grant encoding and a width helper.
package mem_port_arbiter_pkg;

    localparam logic TAG_IF = 1'b0;
    localparam logic TAG_DM = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_RD   = 2'd2,
        GNT_WR   = 2'd3
    } gnt_t;

    // Ceiling log2; used with N+1 to size counters that must hold N itself.
    function automatic int clog2(input int unsigned value);
        int r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = int'(i) + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order FIFO of 1-bit owner tags for reads accepted by the memory but not
// yet answered.
module arb_tag_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          push_tag,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          head,
    output logic          full
);

    logic [DEPTH-1:0] tags;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= push_tag;
    end

    assign head = tags[rd_ptr];
    assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch, data read and data write onto one single-port memory and
// routes in-order read responses back to their owners.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int MAX_WAIT    = 8,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          imem_ready,
    output logic          imem_valid,
    input  logic [AW-1:0] imem_addr,
    output logic          imem_rresp,
    output logic [31:0]   imem_rdata,
    input  logic          dmem_rready,
    output logic          dmem_rvalid,
    input  logic [AW-1:0] dmem_raddr,
    output logic          dmem_rresp,
    output logic [31:0]   dmem_rdata,
    input  logic          dmem_wready,
    output logic          dmem_wvalid,
    input  logic [AW-1:0] dmem_waddr,
    input  logic [31:0]   dmem_wdata,
    input  logic [3:0]    dmem_wstrb,
    output logic          mem_ready,
    input  logic          mem_valid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_rresp,
    input  logic [31:0]   mem_rdata,
    output logic          err
);

    localparam int CW = clog2(OUTSTANDING + 1);
    localparam int WW = clog2(MAX_WAIT + 1);

    logic [CW-1:0] count;
    logic          head;
    logic          full;
    logic          rd_ok;
    logic          resp_hit;
    logic          push;
    logic          push_tag;
    logic          pop;
    logic [WW-1:0] if_wait;
    logic [WW-1:0] rd_wait;
    gnt_t          gnt;

    // A response in the same cycle frees a slot, so a full FIFO still admits a read.
    assign rd_ok    = !full || mem_rresp;
    assign resp_hit = mem_rresp && (count != '0);

    always_comb begin
        gnt = GNT_NONE;
        if (imem_ready && rd_ok && if_wait == WW'(MAX_WAIT))
            gnt = GNT_IF;
        else if (dmem_rready && rd_ok && rd_wait == WW'(MAX_WAIT))
            gnt = GNT_RD;
        else if (dmem_wready)
            gnt = GNT_WR;
        else if (dmem_rready && rd_ok)
            gnt = GNT_RD;
        else if (imem_ready && rd_ok)
            gnt = GNT_IF;
    end

    always_comb begin
        mem_ready   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wstrb   = '0;
        imem_valid  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_wvalid = 1'b0;
        if (!reset) begin
            case (gnt)
                GNT_IF: begin
                    mem_ready  = 1'b1;
                    mem_addr   = imem_addr;
                    imem_valid = mem_valid;
                end
                GNT_RD: begin
                    mem_ready   = 1'b1;
                    mem_addr    = dmem_raddr;
                    dmem_rvalid = mem_valid;
                end
                GNT_WR: begin
                    mem_ready   = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = dmem_waddr;
                    mem_wdata   = dmem_wdata;
                    mem_wstrb   = dmem_wstrb;
                    dmem_wvalid = mem_valid;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_rresp = 1'b0;
        imem_rdata = '0;
        dmem_rresp = 1'b0;
        dmem_rdata = '0;
        if (!reset && resp_hit) begin
            if (head == TAG_IF) begin
                imem_rresp = 1'b1;
                imem_rdata = mem_rdata;
            end else begin
                dmem_rresp = 1'b1;
                dmem_rdata = mem_rdata;
            end
        end
    end

    assign push     = imem_valid || dmem_rvalid;
    assign push_tag = dmem_rvalid ? TAG_DM : TAG_IF;
    assign pop      = !reset && resp_hit;

    arb_tag_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .count    (count),
        .head     (head),
        .full     (full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            if_wait <= '0;
            rd_wait <= '0;
            err     <= 1'b0;
        end else begin
            if (imem_ready && !imem_valid)
                if_wait <= (if_wait == WW'(MAX_WAIT)) ? if_wait : if_wait + 1'b1;
            else
                if_wait <= '0;
            if (dmem_rready && !dmem_rvalid)
                rd_wait <= (rd_wait == WW'(MAX_WAIT)) ? rd_wait : rd_wait + 1'b1;
            else
                rd_wait <= '0;
            if (mem_rresp && count == '0)
                err <= 1'b1;
        end
    end

endmodule
